bmem_arbiter: RTL and testbench

- Two-client arbiter between the instruction cache's bmem-side port and the data cache's bmem-side port; drives the single shared bmem interface.
- Serializes whole transactions:
  - a read is one request plus BURST_LEN returned beats;
  - a write is BURST_LEN accepted beats.
- Routes read-return beats only to the client that owns the transaction.
- Round-robin fairness when both clients request in the same cycle.

---
 rtl/bmem_arbiter.sv | 137 +++++++++++++
 tb/tb_bmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// Two-client bmem arbiter: icache reads and dcache reads/writes share one burst memory port.
// Whole transactions are serialized with round-robin on ties; return beats reach only the owner.
module bmem_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_bmem_addr,
  input  logic        i_bmem_read,
  output logic        i_bmem_ready,
  output logic [31:0] i_bmem_raddr,
  output logic [63:0] i_bmem_rdata,
  output logic        i_bmem_rvalid,
  input  logic [31:0] d_bmem_addr,
  input  logic        d_bmem_read,
  input  logic        d_bmem_write,
  input  logic [63:0] d_bmem_wdata,
  output logic        d_bmem_ready,
  output logic [31:0] d_bmem_raddr,
  output logic [63:0] d_bmem_rdata,
  output logic        d_bmem_rvalid,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, GNT_I_RD, GNT_D_RD, GNT_D_WR, WAIT_I, WAIT_D} state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          i_req, d_req, pick_d;

  assign i_req  = i_bmem_read;
  assign d_req  = d_bmem_read | d_bmem_write;
  // On a tie the client that did not win the previous grant goes first.
  assign pick_d = d_req & (~i_req | ~last_gnt_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          beat_cnt_d = '0;
          last_gnt_d = pick_d;
          if (!pick_d)          state_d = GNT_I_RD;
          else if (d_bmem_write) state_d = GNT_D_WR;
          else                   state_d = GNT_D_RD;
        end
      end
      GNT_I_RD: begin
        if (bmem_ready) begin
          state_d    = WAIT_I;
          beat_cnt_d = '0;
        end
      end
      GNT_D_RD: begin
        if (bmem_ready) begin
          state_d    = WAIT_D;
          beat_cnt_d = '0;
        end
      end
      GNT_D_WR: begin
        if (d_bmem_write & bmem_ready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WAIT_I, WAIT_D: begin
        if (bmem_rvalid) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Return data is broadcast; only rvalid carries ownership.
  assign i_bmem_raddr = bmem_raddr;
  assign i_bmem_rdata = bmem_rdata;
  assign d_bmem_raddr = bmem_raddr;
  assign d_bmem_rdata = bmem_rdata;

  always_comb begin
    bmem_addr     = '0;
    bmem_read     = 1'b0;
    bmem_write    = 1'b0;
    bmem_wdata    = '0;
    i_bmem_ready  = 1'b0;
    d_bmem_ready  = 1'b0;
    i_bmem_rvalid = 1'b0;
    d_bmem_rvalid = 1'b0;
    case (state_q)
      GNT_I_RD: begin
        bmem_addr    = i_bmem_addr;
        bmem_read    = i_bmem_read;
        i_bmem_ready = bmem_ready;
      end
      GNT_D_RD: begin
        bmem_addr    = d_bmem_addr;
        bmem_read    = d_bmem_read;
        d_bmem_ready = bmem_ready;
      end
      GNT_D_WR: begin
        bmem_addr    = d_bmem_addr;
        bmem_write   = d_bmem_write;
        bmem_wdata   = d_bmem_wdata;
        d_bmem_ready = bmem_ready;
      end
      WAIT_I:  i_bmem_rvalid = bmem_rvalid;
      WAIT_D:  d_bmem_rvalid = bmem_rvalid;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: the bench plays both caches and the memory, and a transaction-level
// model predicts every cycle's outputs plus end-to-end data, write-beat and grant-order results.
module tb_bmem_arbiter;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] i_bmem_addr, i_bmem_raddr, d_bmem_addr, d_bmem_raddr, bmem_addr, bmem_raddr;
  logic        i_bmem_read, i_bmem_ready, i_bmem_rvalid;
  logic        d_bmem_read, d_bmem_write, d_bmem_ready, d_bmem_rvalid;
  logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0] i_bmem_rdata, d_bmem_wdata, d_bmem_rdata, bmem_wdata, bmem_rdata;

  bmem_arbiter #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .i_bmem_addr(i_bmem_addr), .i_bmem_read(i_bmem_read), .i_bmem_ready(i_bmem_ready),
    .i_bmem_raddr(i_bmem_raddr), .i_bmem_rdata(i_bmem_rdata), .i_bmem_rvalid(i_bmem_rvalid),
    .d_bmem_addr(d_bmem_addr), .d_bmem_read(d_bmem_read), .d_bmem_write(d_bmem_write),
    .d_bmem_wdata(d_bmem_wdata), .d_bmem_ready(d_bmem_ready), .d_bmem_raddr(d_bmem_raddr),
    .d_bmem_rdata(d_bmem_rdata), .d_bmem_rvalid(d_bmem_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // icache client
  bit ic_req; logic [31:0] ic_a; int ic_left, ic_k, ic_issued, ic_done;
  // dcache client
  bit dc_req, dc_wr, dc_stall; logic [31:0] dc_a; int dc_wb, dc_left, dc_k, dc_issued, dc_done;
  // observations
  int ic_rv_cnt, dc_rv_cnt, ic_rdy_cnt, first_rd_cyc, w2_cnt; logic [63:0] w2_watch;
  logic [31:0] accept_log[$];
  // memory
  logic [31:0] rd_q[$]; int ret_k, rdy_low, rdy_pct, rv_pct, stray_n; bit mem_pause;
  logic [63:0] wq[$], exp_wq[$];
  // reference: current transaction (-1 none, 0 icache read, 1 dcache read, 2 dcache write)
  int t_own, t_cnt; bit t_ret, m_last;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  function automatic logic [63:0] wr_word(input logic [31:0] a, input int k);
    return {32'hC0DE_0000 | 32'(k), a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit quiet();
    return !ic_req && ic_left == 0 && !dc_req && dc_left == 0 && rd_q.size() == 0;
  endfunction

  task automatic issue_ic(input logic [31:0] a);
    ic_req = 1; ic_a = a; ic_issued++;
  endtask

  task automatic issue_dc(input logic [31:0] a, input bit wr);
    dc_req = 1; dc_wr = wr; dc_a = a; dc_wb = 0; dc_issued++;
    if (wr) for (int k = 0; k < BL; k++) exp_wq.push_back(wr_word(a, k));
  endtask

  task automatic clear_obs();
    ic_rv_cnt = 0; dc_rv_cnt = 0; ic_rdy_cnt = 0; w2_cnt = 0; first_rd_cyc = -1;
    accept_log.delete();
  endtask

  task automatic cycle();
    bit from_q;
    bit ireq, dreq;
    logic e_rd, e_wr, e_irdy, e_drdy, e_irv, e_drv;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
    i_bmem_read  = ic_req;
    i_bmem_addr  = ic_req ? ic_a : 32'h0;
    d_bmem_read  = dc_req && !dc_wr;
    d_bmem_write = dc_req && dc_wr && !dc_stall;
    d_bmem_addr  = dc_req ? dc_a : 32'h0;
    d_bmem_wdata = (dc_req && dc_wr) ? wr_word(dc_a, dc_wb) : 64'h0;
    bmem_ready   = (rdy_low > 0) ? 1'b0 : 1'($urandom_range(99) < rdy_pct);
    from_q = 0;
    bmem_rvalid = 1'b0;
    bmem_raddr  = $urandom;
    bmem_rdata  = {$urandom, $urandom};
    if (!mem_pause) begin
      if (stray_n > 0) bmem_rvalid = 1'b1;
      else if (rd_q.size() > 0 && $urandom_range(99) < rv_pct) begin
        from_q = 1; bmem_rvalid = 1'b1;
        bmem_raddr = rd_q[0] + 32'(8 * ret_k);
        bmem_rdata = mem_word(bmem_raddr);
      end
    end
    #1;
    if (!rst) begin
      {e_rd, e_wr, e_irdy, e_drdy, e_irv, e_drv} = '0;
      e_addr = '0; e_wd = '0;
      if (t_own >= 0 && !t_ret) begin
        if (t_own == 0) begin e_addr = i_bmem_addr; e_rd = i_bmem_read; e_irdy = bmem_ready; end
        else if (t_own == 1) begin e_addr = d_bmem_addr; e_rd = d_bmem_read; e_drdy = bmem_ready; end
        else begin
          e_addr = d_bmem_addr; e_wr = d_bmem_write; e_wd = d_bmem_wdata; e_drdy = bmem_ready;
        end
      end else if (t_ret) begin
        if (t_own == 0) e_irv = bmem_rvalid; else e_drv = bmem_rvalid;
      end
      chk("bmem_addr", bmem_addr, e_addr);
      chk("bmem_rd_wr", {bmem_read, bmem_write}, {e_rd, e_wr});
      chk("bmem_wdata", bmem_wdata, e_wd);
      chk("client_ready", {i_bmem_ready, d_bmem_ready}, {e_irdy, e_drdy});
      chk("client_rvalid", {i_bmem_rvalid, d_bmem_rvalid}, {e_irv, e_drv});
      chk("ret_raddr", {i_bmem_raddr, d_bmem_raddr}, {bmem_raddr, bmem_raddr});
      chk("ret_rdata_i", i_bmem_rdata, bmem_rdata);
      chk("ret_rdata_d", d_bmem_rdata, bmem_rdata);
    end
    // reference transaction bookkeeping
    ireq = i_bmem_read; dreq = d_bmem_read | d_bmem_write;
    if (rst) begin
      t_own = -1; t_ret = 0; m_last = 1;
    end else if (t_own < 0) begin
      if (ireq && (!dreq || m_last)) begin t_own = 0; m_last = 0; end
      else if (dreq) begin t_own = d_bmem_write ? 2 : 1; m_last = 1; end
      t_cnt = 0; t_ret = 0;
    end else if (!t_ret) begin
      if (t_own == 2) begin
        if (d_bmem_write && bmem_ready && ++t_cnt == BL) t_own = -1;
      end else if (bmem_ready) begin
        t_ret = 1; t_cnt = 0;
      end
    end else if (bmem_rvalid && ++t_cnt == BL) begin
      t_own = -1; t_ret = 0;
    end
    // clients and memory react to the handshakes they saw
    if (rst) begin
      ic_req = 0; ic_left = 0; dc_req = 0; dc_left = 0;
    end else begin
      if (i_bmem_ready) ic_rdy_cnt++;
      if (i_bmem_rvalid) ic_rv_cnt++;
      if (d_bmem_rvalid) dc_rv_cnt++;
      if (bmem_read && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (bmem_write && bmem_wdata == w2_watch) w2_cnt++;
      if (ic_left == 0) chk("i_rvalid_unowned", i_bmem_rvalid, 1'b0);
      else if (i_bmem_rvalid) begin
        chk("i_raddr", i_bmem_raddr, ic_a + 32'(8 * ic_k));
        chk("i_rdata", i_bmem_rdata, mem_word(ic_a + 32'(8 * ic_k)));
        ic_k++;
        if (--ic_left == 0) ic_done++;
      end
      if (dc_left == 0) chk("d_rvalid_unowned", d_bmem_rvalid, 1'b0);
      else if (d_bmem_rvalid) begin
        chk("d_rdata", d_bmem_rdata, mem_word(dc_a + 32'(8 * dc_k)));
        dc_k++;
        if (--dc_left == 0) dc_done++;
      end
      if (ic_req && i_bmem_ready) begin
        ic_req = 0; ic_left = BL; ic_k = 0; accept_log.push_back(ic_a);
      end
      if (dc_req && !dc_wr && d_bmem_ready) begin
        dc_req = 0; dc_left = BL; dc_k = 0; accept_log.push_back(dc_a);
      end else if (dc_req && dc_wr && d_bmem_write && d_bmem_ready) begin
        if (dc_wb == 0) accept_log.push_back(dc_a);
        if (++dc_wb == BL) begin dc_req = 0; dc_done++; end
      end
      if (bmem_read && bmem_ready) rd_q.push_back(bmem_addr);
      if (bmem_write && bmem_ready) wq.push_back(bmem_wdata);
    end
    if (from_q && ++ret_k == BL) begin void'(rd_q.pop_front()); ret_k = 0; end
    if (stray_n > 0 && !mem_pause) stray_n--;
    if (rdy_low > 0) rdy_low--;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin cycle(); n++; end
    chk("drain_in_budget", quiet(), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  initial begin
    int n;
    ic_req = 0; dc_req = 0; dc_wr = 0; dc_stall = 0; ic_left = 0; dc_left = 0;
    ic_issued = 0; ic_done = 0; dc_issued = 0; dc_done = 0; ret_k = 0;
    rdy_low = 0; rdy_pct = 100; rv_pct = 100; stray_n = 0; mem_pause = 0;
    t_own = -1; t_ret = 0; t_cnt = 0; m_last = 1; w2_watch = '1;
    clear_obs();
    do_reset();

    // reset state with quiet inputs
    {i_bmem_read, d_bmem_read, d_bmem_write, bmem_ready, bmem_rvalid} = '0;
    i_bmem_addr = '0; d_bmem_addr = '0; d_bmem_wdata = '0; bmem_raddr = '0; bmem_rdata = '0;
    #1;
    chk("rst_bmem", {bmem_addr, bmem_read, bmem_write}, 64'h0);
    chk("rst_wdata", bmem_wdata, 64'h0);
    chk("rst_client", {i_bmem_ready, i_bmem_rvalid, d_bmem_ready, d_bmem_rvalid}, 64'h0);
    chk("rst_ret", {i_bmem_raddr, d_bmem_raddr}, 64'h0);

    // lone icache read
    clear_obs();
    issue_ic(32'h1000_0040);
    n = cyc;
    wait_idle(50);
    chk("first_read_latency", 64'(first_rd_cyc - n), 64'd1);
    chk("lone_i_beats", 64'(ic_rv_cnt), 64'd4);
    chk("lone_d_beats", 64'(dc_rv_cnt), 64'd0);

    // tie out of reset, then icache re-requests while dcache still waits
    do_reset();
    clear_obs();
    issue_ic(32'h100);
    issue_dc(32'h200, 0);
    n = ic_done;
    for (int k = 0; k < 50 && ic_done == n; k++) cycle();
    issue_ic(32'h140);
    wait_idle(80);
    chk("tie_order_len", 64'(accept_log.size()), 64'd3);
    if (accept_log.size() == 3) begin
      chk("tie1_winner", accept_log[0], 32'h100);
      chk("tie1_loser", accept_log[1], 32'h200);
      chk("tie2_last", accept_log[2], 32'h140);
    end

    // dcache write with memory stalling beat 2 for two cycles
    clear_obs(); wq.delete(); exp_wq.delete();
    w2_watch = wr_word(32'h300, 2);
    issue_dc(32'h300, 1);
    for (int k = 0; k < 30 && dc_wb < 2; k++) cycle();
    rdy_low = 2;
    wait_idle(40);
    chk("wr_beats", 64'(wq.size()), 64'd4);
    for (int k = 0; k < 4 && k < wq.size(); k++) chk("wr_data", wq[k], wr_word(32'h300, k));
    chk("wr_w2_held", 64'(w2_cnt), 64'd3);
    chk("wr_i_ready", 64'(ic_rdy_cnt), 64'd0);
    w2_watch = '1;

    // icache request arriving during a write burst waits for it
    clear_obs();
    issue_dc(32'h400, 1);
    cycle(); cycle();
    issue_ic(32'h1000_0080);
    wait_idle(60);
    chk("wr_then_rd_len", 64'(accept_log.size()), 64'd2);
    if (accept_log.size() == 2) begin
      chk("wr_then_rd_0", accept_log[0], 32'h400);
      chk("wr_then_rd_1", accept_log[1], 32'h1000_0080);
    end

    // reset in the middle of a dcache read return; leftover beats must be dropped
    issue_dc(32'h500, 0);
    for (int k = 0; k < 30 && !(dc_left > 0 && dc_k == 2); k++) cycle();
    mem_pause = 1; rst = 1;
    cycle();
    rst = 0; mem_pause = 0;
    clear_obs();
    repeat (3) cycle();
    chk("stray_after_rst", 64'(ic_rv_cnt + dc_rv_cnt), 64'd0);
    chk("stray_drained", 64'(rd_q.size()), 64'd0);
    n = dc_done;
    issue_dc(32'h600, 0);
    wait_idle(40);
    chk("post_rst_read", 64'(dc_done - n), 64'd1);
    chk("post_rst_beats", 64'(dc_rv_cnt), 64'd4);

    // stray return beats while idle
    clear_obs();
    stray_n = 2;
    repeat (3) cycle();
    chk("stray_idle", 64'(ic_rv_cnt + dc_rv_cnt), 64'd0);
    issue_ic(32'h1000_0100);
    wait_idle(40);
    chk("after_stray_read", 64'(ic_rv_cnt), 64'd4);

    // randomized traffic with memory backpressure and return gaps
    wq.delete(); exp_wq.delete();
    ic_issued = 0; ic_done = 0; dc_issued = 0; dc_done = 0;
    rdy_pct = 70; rv_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      if (!ic_req && ic_left == 0 && $urandom_range(3) == 0)
        issue_ic(32'h1000_0000 | ($urandom & 32'h000F_FFE0));
      if (!dc_req && dc_left == 0 && $urandom_range(3) == 0)
        issue_dc(32'h2000_0000 | ($urandom & 32'h000F_FFE0), 1'($urandom_range(1)));
      dc_stall = dc_req && dc_wr && dc_wb > 0 && $urandom_range(4) == 0;
      cycle();
    end
    dc_stall = 0;
    wait_idle(200);
    chk("rand_ic_complete", 64'(ic_done), 64'(ic_issued));
    chk("rand_dc_complete", 64'(dc_done), 64'(dc_issued));
    chk("rand_wr_count", 64'(wq.size()), 64'(exp_wq.size()));
    for (int k = 0; k < wq.size() && k < exp_wq.size(); k++) chk("rand_wr_data", wq[k], exp_wq[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
